program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/program_loader.sv | 157 +++++++++++++++
 tb/tb_program_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its timeout counter.
package loader_pkg;
    typedef enum logic [2:0] {
        IDLE, ACCEPT, WRITE, VADDR, VCHECK, RUN, FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_VERIFY  = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    localparam logic MODE_PROG = 1'b1;
    localparam logic MODE_RUN  = 1'b0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; term flags the limit value.
module sat_counter #(
    parameter int WIDTH = 10,
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic term
);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   count <= '0;
        else if (clr)                 count <= '0;
        else if (en && count != LIM)  count <= count + WIDTH'(1);
    end

    assign term = (count == LIM);
endmodule

// File: rtl/program_loader.sv
// Streams program bytes into CPU RAM, optionally reads them back for checking,
// then releases the CPU into run mode and waits for halt with a timeout.
module program_loader
    import loader_pkg::*;
#(
    parameter int NWORDS  = 16,
    parameter int VERIFY  = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       mode,
    output logic [7:0] instr,
    output logic [3:0] addr,
    output logic       WEN,
    input  logic [7:0] ramload,
    input  logic       halt,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [3:0] err_addr
);
    localparam logic [3:0] LAST      = 4'(NWORDS - 1);
    localparam bit         VERIFY_EN = (VERIFY != 0);

    state_t     state, state_n;
    err_t       err_q;
    logic [3:0] cnt;
    logic       start_pend;
    logic       tmo;
    logic       mismatch;
    logic [7:0] shadow [NWORDS];

    assign err      = err_q;
    assign mismatch = (ramload != shadow[cnt]);

    sat_counter #(.WIDTH(10), .LIMIT(TIMEOUT)) u_tmo (
        .clk   (CLK),
        .rst_n (nRST),
        .en    (state == RUN),
        .clr   (state != RUN),
        .term  (tmo)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        WEN        = 1'b0;
        mode       = MODE_PROG;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start || start_pend) state_n = ACCEPT;
            end
            ACCEPT: begin
                byte_ready = 1'b1;
                if (byte_valid) state_n = WRITE;
            end
            WRITE: begin
                WEN = 1'b1;
                if (cnt != LAST)    state_n = ACCEPT;
                else if (VERIFY_EN) state_n = VADDR;
                else                state_n = RUN;
            end
            VADDR:  state_n = VCHECK;
            VCHECK: begin
                if (mismatch)         state_n = FINISH;
                else if (cnt == LAST) state_n = RUN;
                else                  state_n = VADDR;
            end
            RUN: begin
                mode = MODE_RUN;
                if (halt || tmo) state_n = FINISH;
            end
            FINISH: begin
                busy    = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // addr is loaded on the edge entering VADDR so RAM data lines up with VCHECK
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt        <= '0;
            addr       <= '0;
            instr      <= '0;
            done       <= 1'b0;
            err_q      <= ERR_NONE;
            err_addr   <= '0;
            start_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    start_pend <= 1'b0;
                    if (start || start_pend) begin
                        cnt      <= '0;
                        done     <= 1'b0;
                        err_q    <= ERR_NONE;
                        err_addr <= '0;
                    end
                end
                ACCEPT: begin
                    if (byte_valid) begin
                        instr <= byte_data;
                        addr  <= cnt;
                    end
                end
                WRITE: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 4'd1;
                    end else if (VERIFY_EN) begin
                        cnt  <= '0;
                        addr <= '0;
                    end
                end
                VCHECK: begin
                    if (mismatch) begin
                        err_q    <= ERR_VERIFY;
                        err_addr <= cnt;
                        done     <= 1'b1;
                    end else if (cnt != LAST) begin
                        cnt  <= cnt + 4'd1;
                        addr <= cnt + 4'd1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        done <= 1'b1;
                    end else if (tmo) begin
                        err_q <= ERR_TIMEOUT;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    if (start) start_pend <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == ACCEPT && byte_valid) shadow[cnt] <= byte_data;
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader with a RAM model and halt driver.
module tb_program_loader;
    localparam int NW  = 16;
    localparam int TMO = 1023;

    typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [1:0] err; logic [3:0] eaddr; int rmin; int rmax; } res_t;

    logic       CLK = 1'b0, nRST = 1'b0, start = 1'b0, byte_valid = 1'b0, halt = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [7:0] ramload;
    logic       byte_ready, mode, WEN, busy, done;
    logic [7:0] instr;
    logic [3:0] addr, err_addr;
    logic [1:0] err;

    int         n_cmp = 0, n_fail = 0;
    bit         bad_en = 1'b0;
    logic [3:0] bad_addr = 4'd0;
    logic [7:0] cur_bytes [NW];
    logic [7:0] mem [NW];
    wr_t        exp_wr [$];
    res_t       exp_res [$];

    always #5 CLK = ~CLK;

    program_loader #(.NWORDS(NW), .VERIFY(1), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mode(mode),
        .instr(instr), .addr(addr), .WEN(WEN), .ramload(ramload),
        .halt(halt), .busy(busy), .done(done), .err(err), .err_addr(err_addr)
    );

    // CPU RAM: synchronous write, one-cycle read latency, optional stuck location
    always @(posedge CLK) begin
        if (WEN) mem[addr] <= instr;
        ramload <= (bad_en && addr == bad_addr) ? 8'hFF : mem[addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got bound expired expected DUT event", nm);
    endtask

    // Outcome computed from the loader's rules, not from its state machine
    function automatic res_t model(input bit be, input logic [3:0] ba, input int hm);
        res_t r;
        r.eaddr = ba;
        if (be && cur_bytes[ba] != 8'hFF) begin
            r.err = 2'b01; r.rmin = 0; r.rmax = 0;
        end else if (hm == 0) begin
            r.err = 2'b10; r.rmin = TMO; r.rmax = TMO + 1;
        end else if (hm == 1) begin
            r.err = 2'b00; r.rmin = 41; r.rmax = 41;
        end else begin
            r.err = 2'b00; r.rmin = 1; r.rmax = 1;
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on every WEN pulse and on every done rise
    int  acc_cnt = 0, wen_cnt = 0, run_cnt = 0;
    bit  done_d = 1'b0;
    always @(negedge CLK) begin
        wr_t  w;
        res_t r;
        if (nRST) begin
            if (byte_ready && byte_valid) acc_cnt++;
            if (!mode) run_cnt++;
            if (WEN) begin
                chk("wen_after_accept", 32'(acc_cnt > wen_cnt), 1);
                wen_cnt++;
                chk("wen_expected", 32'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", addr, w.a);
                    chk("wr_data", instr, w.d);
                end
            end
            if (done && !done_d) begin
                chk("done_expected", 32'(exp_res.size() > 0), 1);
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    chk("err", err, r.err);
                    if (r.err == 2'b01) chk("err_addr", err_addr, r.eaddr);
                    if (run_cnt < r.rmin || run_cnt > r.rmax) begin
                        n_cmp++; n_fail++;
                        $display("FAIL run_cycles: got %0d expected %0d..%0d", run_cnt, r.rmin, r.rmax);
                    end else n_cmp++;
                end
                run_cnt = 0;
            end
        end else run_cnt = 0;
        done_d = done;
    end

    task automatic begin_seq(input int hm, input bit be, input logic [3:0] ba);
        wr_t w;
        bad_en   = be;
        bad_addr = ba;
        halt     = (hm == 2);
        for (int i = 0; i < NW; i++) begin
            w.a = 4'(i); w.d = cur_bytes[i];
            exp_wr.push_back(w);
        end
        exp_res.push_back(model(be, ba, hm));
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
    endtask

    task automatic load(input int vm, input bit st_acc, input int abort_at,
                        output int cyc, output bit aborted);
        int k = 0;
        int it = 0;
        cyc = 0;
        aborted = 1'b0;
        while (k < NW) begin
            if (it >= 400) begin fail_now("load_budget"); return; end
            if (vm == 0)      byte_valid = 1'b1;
            else if (vm == 1) byte_valid = ((it / 3) % 2) == 0;
            else              byte_valid = 1'($urandom_range(0, 1));
            byte_data = cur_bytes[k];
            start     = st_acc && (it == 5);
            @(negedge CLK);
            if (byte_ready || WEN) cyc++;
            if (abort_at >= 0 && WEN && addr == 4'(abort_at)) begin
                #2 nRST = 1'b0;
                start = 1'b0; byte_valid = 1'b0; aborted = 1'b1;
                return;
            end
            if (byte_ready && byte_valid) k++;
            @(posedge CLK); #1;
            it++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        @(negedge CLK);
        if (WEN) cyc++;
    endtask

    task automatic wait_done(input int hm, input bit fin_start);
        int low = 0;
        bit got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            if (hm == 1 && low >= 40) halt = 1'b1;
            @(negedge CLK);
            if (!mode) low++;
            if (done) begin got = 1'b1; break; end
        end
        if (!got) begin fail_now("done_wait"); return; end
        chk("finish_busy", busy, 0);
        chk("finish_mode", mode, 1);
        halt = 1'b0;
        if (fin_start) begin
            start = 1'b1;
            @(posedge CLK); #1 start = 1'b0;
            @(negedge CLK);
            chk("idle_gap_ready", byte_ready, 0);
            chk("done_held", done, 1);
            @(posedge CLK); #1;
            chk("fin_start_ready", byte_ready, 1);
            chk("fin_start_busy", busy, 1);
        end
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < NW; i++) cur_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mode"}, mode, 1);
        chk({tag, "_wen"}, WEN, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_ready"}, byte_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_addr"}, err_addr, 0);
    endtask

    initial begin
        int cyc;
        bit ab;
        int hm, vm;
        bit be;
        #23 chk_reset("rst");
        @(negedge CLK) nRST = 1'b1;

        for (int i = 0; i < NW; i++) cur_bytes[i] = 8'(i);
        begin_seq(1, 1'b0, 4'd0);
        pulse_start();
        load(0, 1'b0, -1, cyc, ab);
        chk("load_cycles", cyc, 32);
        wait_done(1, 1'b0);

        rand_bytes();
        begin_seq(2, 1'b0, 4'd0);
        pulse_start();
        load(1, 1'b1, -1, cyc, ab);
        wait_done(2, 1'b0);

        rand_bytes();
        if (cur_bytes[5] == 8'hFF) cur_bytes[5] = 8'h5A;
        begin_seq(0, 1'b1, 4'd5);
        pulse_start();
        load(2, 1'b0, -1, cyc, ab);
        wait_done(0, 1'b0);

        rand_bytes();
        begin_seq(0, 1'b0, 4'd0);
        pulse_start();
        load(0, 1'b0, -1, cyc, ab);
        wait_done(0, 1'b1);
        rand_bytes();
        begin_seq(1, 1'b0, 4'd0);
        load(2, 1'b0, -1, cyc, ab);
        wait_done(1, 1'b0);

        rand_bytes();
        begin_seq(2, 1'b0, 4'd0);
        pulse_start();
        load(0, 1'b0, 7, cyc, ab);
        chk("abort_hit", ab, 1);
        #1 chk_reset("midrst");
        exp_wr.delete();
        exp_res.delete();
        repeat (3) begin
            @(negedge CLK);
            chk("rst_no_wen", WEN, 0);
        end
        nRST = 1'b1;
        halt = 1'b0;

        rand_bytes();
        begin_seq(2, 1'b0, 4'd0);
        pulse_start();
        load(0, 1'b0, -1, cyc, ab);
        wait_done(2, 1'b0);

        for (int s = 0; s < 4; s++) begin
            rand_bytes();
            hm = $urandom_range(1, 2);
            be = 1'($urandom_range(0, 1));
            vm = $urandom_range(0, 2);
            begin_seq(hm, be, 4'($urandom_range(0, NW - 1)));
            pulse_start();
            load(vm, 1'b0, -1, cyc, ab);
            wait_done(hm, 1'b0);
        end

        repeat (5) @(negedge CLK);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: got no finish expected finish before 600000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
